// File: rtl/argmax_seq_ctrl.sv
// ---------------------------------------------------------------------------
// argmax_seq_ctrl
//
// Sequential classifier controller at the tail of the fully-connected
// pipeline. A start request walks the final-layer output buffer one word per
// cycle. A single signed comparator keeps a running maximum and the index at
// which it occurred, so the comparator cost does not grow with LAYER_SZ. When
// the walk ends, the winning class index is published with a one-cycle done
// pulse.
//
// Ports
//   clk          in   1        clock, all state updates on the rising edge
//   rst          in   1        synchronous reset, active-high
//   start        in   1        request a classification run (sampled in IDLE)
//   busy         out  1        high from the cycle after an accepted start
//                              through the done cycle
//   rd_en        out  1        output-buffer read enable
//   rd_addr      out  ADDR_W   output-buffer read address (0 when rd_en=0)
//   rd_data      in   SIZE     signed buffer word, valid 1 cycle after rd_en
//   done         out  1        one-cycle pulse: class_out/max_value updated
//   class_valid  out  1        class_out holds the result of the latest run
//   class_out    out  SIZE     winning index zero-extended, all-ones if none
//   max_value    out  SIZE     signed maximum found
// ---------------------------------------------------------------------------
module argmax_seq_ctrl #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 10,
  parameter int ADDR_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [SIZE-1:0]   rd_data,
  output logic                     done,
  output logic                     class_valid,
  output logic [SIZE-1:0]          class_out,
  output logic signed [SIZE-1:0]   max_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(LAYER_SZ - 1);
  localparam logic signed [SIZE-1:0] SIZE_MIN  = {1'b1, {(SIZE-1){1'b0}}};

  // Strict compare: equal values never displace the incumbent, which keeps
  // the lowest index among tied maxima.
  function automatic logic beats(input logic signed [SIZE-1:0] cand,
                                 input logic signed [SIZE-1:0] cur);
    return cand > cur;
  endfunction

  // No strict update during a run means no word exceeded SIZE_MIN; report
  // all-ones instead of an index.
  function automatic logic [SIZE-1:0] class_word(input logic              found,
                                                 input logic [ADDR_W-1:0] idx);
    return found ? SIZE'(idx) : {SIZE{1'b1}};
  endfunction

  // Control registers
  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic                      done_q, done_d;
  logic                      class_valid_q, class_valid_d;
  logic [SIZE-1:0]           class_out_q, class_out_d;
  logic signed [SIZE-1:0]    max_value_q, max_value_d;
  logic                      vld_p1_q;

  // Datapath registers (initialised on every accepted start, no reset)
  logic [ADDR_W-1:0]         addr_p1_q;
  logic signed [SIZE-1:0]    run_max_q, run_max_d;
  logic [ADDR_W-1:0]         run_idx_q, run_idx_d;
  logic                      run_found_q, run_found_d;

  logic                      accept;
  logic                      upd_p1;

  assign accept = (state_q == S_IDLE) && start;
  assign upd_p1 = vld_p1_q && beats(rd_data, run_max_q);

  // Running maximum. In FLUSH the last word is compared here, and the FSM
  // publishes the _d values so DONE already carries the final result.
  always_comb begin
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    run_found_d = run_found_q;
    if (accept) begin
      run_max_d   = SIZE_MIN;
      run_idx_d   = {ADDR_W{1'b1}};
      run_found_d = 1'b0;
    end else if (upd_p1) begin
      run_max_d   = rd_data;
      run_idx_d   = addr_p1_q;
      run_found_d = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = '0;
    done_d        = 1'b0;
    class_valid_d = class_valid_q;
    class_out_d   = class_out_q;
    max_value_d   = max_value_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d       = S_READ;
          busy_d        = 1'b1;
          rd_en_d       = 1'b1;
          rd_addr_d     = '0;
          class_valid_d = 1'b0;
        end
      end
      S_READ: begin
        busy_d = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_FLUSH;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        state_d       = S_DONE;
        busy_d        = 1'b1;
        done_d        = 1'b1;
        class_valid_d = 1'b1;
        class_out_d   = class_word(run_found_d, run_idx_d);
        max_value_d   = run_max_d;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      done_q        <= 1'b0;
      class_valid_q <= 1'b0;
      class_out_q   <= {SIZE{1'b1}};
      max_value_q   <= SIZE_MIN;
      vld_p1_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      done_q        <= done_d;
      class_valid_q <= class_valid_d;
      class_out_q   <= class_out_d;
      max_value_q   <= max_value_d;
      // p0 -> p1: read issued this cycle returns data next cycle
      vld_p1_q      <= rd_en_q;
    end
  end

  always_ff @(posedge clk) begin
    // p0 -> p1: address travels with the read so the index matches rd_data
    addr_p1_q   <= rd_addr_q;
    // p1 -> running state
    run_max_q   <= run_max_d;
    run_idx_q   <= run_idx_d;
    run_found_q <= run_found_d;
  end

  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign done        = done_q;
  assign class_valid = class_valid_q;
  assign class_out   = class_out_q;
  assign max_value   = max_value_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
module tb_argmax_seq_ctrl;
  localparam int SIZE = 16;
  localparam int L    = 4;
  localparam int AW   = 4;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic                   busy;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic signed [SIZE-1:0] rd_data;
  logic                   done;
  logic                   class_valid;
  logic [SIZE-1:0]        class_out;
  logic signed [SIZE-1:0] max_value;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic signed [SIZE-1:0] mem [L];

  argmax_seq_ctrl #(.SIZE(SIZE), .LAYER_SZ(L), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .class_valid(class_valid), .class_out(class_out), .max_value(max_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One-cycle-latency output buffer: a read seen in cycle n returns data in
  // cycle n+1; otherwise the bus carries random junk.
  logic          pend_en;
  logic [AW-1:0] pend_addr;
  initial forever begin
    @(negedge clk);
    pend_en   = rd_en;
    pend_addr = rd_addr;
    @(posedge clk);
    #1;
    if (pend_en === 1'b1 && pend_addr < AW'(L))
      rd_data = mem[pend_addr[1:0]];
    else
      rd_data = SIZE'($urandom);
  end

  // Reference: argmax over the whole buffer, strict > from SIZE_MIN.
  task automatic argmax_ref(output logic [15:0] cls, output logic [15:0] mx);
    int best;
    int idx;
    best = -32768;
    idx  = -1;
    for (int i = 0; i < L; i++) begin
      if (int'(mem[i]) > best) begin
        best = int'(mem[i]);
        idx  = i;
      end
    end
    cls = (idx < 0) ? 16'hFFFF : 16'(idx);
    mx  = 16'(best);
  endtask

  // Behavioural model: a run is a timeline of L+2 busy cycles after accept.
  bit          m_ok  = 1'b0;
  bit          m_act = 1'b0;
  int          m_rel = 0;
  bit          m_cv  = 1'b0;
  logic [15:0] m_cls, m_max, snap_cls, snap_max;

  initial forever begin
    bit e_rden;
    @(negedge clk);
    if (m_ok) begin
      e_rden = m_act && (m_rel <= L);
      check("busy", 16'(busy), 16'(m_act));
      check("rd_en", 16'(rd_en), 16'(e_rden));
      check("rd_addr", 16'(rd_addr), e_rden ? 16'(m_rel - 1) : 16'h0);
      check("done", 16'(done), 16'(m_act && (m_rel == L + 2)));
      check("class_valid", 16'(class_valid), 16'(m_cv));
      check("class_out", class_out, m_cls);
      check("max_value", max_value, m_max);
    end
    if (rst === 1'b1) begin
      m_ok  = 1'b1;
      m_act = 1'b0;
      m_cv  = 1'b0;
      m_cls = 16'hFFFF;
      m_max = 16'h8000;
    end else if (m_ok) begin
      if (m_act) begin
        if (m_rel == L + 2) m_act = 1'b0;
        else begin
          m_rel++;
          if (m_rel == L + 2) begin
            m_cls = snap_cls;
            m_max = snap_max;
            m_cv  = 1'b1;
          end
        end
      end else if (start === 1'b1) begin
        m_act = 1'b1;
        m_rel = 1;
        m_cv  = 1'b0;
        argmax_ref(snap_cls, snap_max);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buf(input int a, input int b, input int c, input int d);
    mem[0] = SIZE'(a);
    mem[1] = SIZE'(b);
    mem[2] = SIZE'(c);
    mem[3] = SIZE'(d);
  endtask

  // Directed run with literal expectations; returns at the done cycle.
  task automatic run_one(input string tag, input int a, input int b, input int c,
                         input int d, input logic [15:0] e_cls, input logic [15:0] e_max);
    int t0;
    int lat;
    tick();
    set_buf(a, b, c, d);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    check({tag, "_latency"}, 16'(lat), 16'd6);
    check({tag, "_class"}, class_out, e_cls);
    check({tag, "_max"}, max_value, e_max);
    check({tag, "_cv"}, 16'(class_valid), 16'd1);
  endtask

  initial begin
    int t0;
    int mode;
    int g;
    bit aborted;
    rst     = 1'b1;
    start   = 1'b0;
    rd_data = '0;
    set_buf(0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_class", class_out, 16'hFFFF);
    check("reset_max", max_value, 16'h8000);
    check("reset_cv", 16'(class_valid), 16'd0);

    run_one("t1", 3, -2, 7, 1, 16'd2, 16'd7);
    run_one("t2", 5, 5, -1, 5, 16'd0, 16'd5);
    run_one("t3", -8, -3, -5, -9, 16'd1, 16'hFFFD);
    run_one("t4", -32768, -32768, -32768, -32768, 16'hFFFF, 16'h8000);

    // start held for 10 cycles: two runs, busy low only in the gap cycle
    tick();
    set_buf(1, 2, 3, 4);
    start = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c >= 10) start = 1'b0;
      @(negedge clk);
      check("t5_done", 16'(done), 16'((c == 6) || (c == 13)));
      check("t5_busy", 16'(busy), 16'((c <= 13) && (c != 7)));
    end
    check("t5_class", class_out, 16'd3);

    // reset in cycle 3 of a run, restart in cycle 6
    tick();
    set_buf(-1, 9, 9, 2);
    start = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = (c == 6);
      rst   = (c == 3);
      @(negedge clk);
      check("t6_done", 16'(done), 16'(c == 12));
      if (c == 4) begin
        check("t6_rst_rden", 16'(rd_en), 16'd0);
        check("t6_rst_busy", 16'(busy), 16'd0);
        check("t6_rst_cv", 16'(class_valid), 16'd0);
        check("t6_rst_class", class_out, 16'hFFFF);
      end
      if (c == 12) begin
        check("t6_class", class_out, 16'd1);
        check("t6_max", max_value, 16'd9);
      end
    end

    // randomized runs: varied data, ignored start glitches, rare resets
    for (int it = 0; it < 250; it++) begin
      tick();
      rst  = 1'b0;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < L; i++) begin
        case (mode)
          0: mem[i] = SIZE'($urandom);
          1: mem[i] = SIZE'(int'($urandom_range(0, 4)) - 2);
          2: case ($urandom_range(0, 3))
               0: mem[i] = 16'sh8000;
               1: mem[i] = 16'sh7FFF;
               2: mem[i] = 16'sh0000;
               default: mem[i] = 16'shFFFF;
             endcase
          default: mem[i] = 16'sh8000;
        endcase
      end
      start   = 1'b1;
      aborted = 1'b0;
      for (int r = 1; r <= L + 2; r++) begin
        tick();
        start = 1'b0;
        rst   = 1'b0;
        if (!aborted) begin
          if ($urandom_range(0, 29) == 0) begin
            rst     = 1'b1;
            aborted = 1'b1;
          end else begin
            start = ($urandom_range(0, 2) == 0);
          end
        end
      end
      g = int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) begin
        tick();
        start = 1'b0;
        rst   = 1'b0;
      end
    end
    tick();
    start = 1'b0;
    rst   = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
